button_debouncer: RTL and testbench

Debounces one raw push-button input using the divided clock from `clock_divider_one` as its sampling strobe. It sits directly downstream of the divider: `clk_div` is edge-detected in the `clk` domain, never used as a clock. The block outputs a clean level plus one-cycle press/release pulses for the board's control logic.

---
 rtl/button_debouncer.sv | 124 ++++++++++++
 tb/tb_button_debouncer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, clk_div rising-edge strobe,
// and a 4-state FSM that emits a clean level plus press/release pulses.
module button_debouncer #(
  parameter int unsigned STABLE_COUNT           = 4,
  parameter int unsigned STABLE_COUNT_BIT_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_div,
  input  logic button_in,
  output logic button_out,
  output logic pressed,
  output logic released
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    PEND_HIGH,
    IDLE_HIGH,
    PEND_LOW
  } state_t;

  localparam logic [STABLE_COUNT_BIT_WIDTH-1:0] COUNT_ONE  = STABLE_COUNT_BIT_WIDTH'(1);
  localparam logic [STABLE_COUNT_BIT_WIDTH-1:0] COUNT_LAST = STABLE_COUNT_BIT_WIDTH'(STABLE_COUNT - 1);

  state_t                            state, state_next;
  logic [STABLE_COUNT_BIT_WIDTH-1:0] count, count_next;
  logic                              btn_meta, btn_sync;
  logic                              clk_div_d;
  logic                              tick;
  logic                              pressed_next, released_next;

  // clk_div is data here; only its rising edge in the clk domain matters
  assign tick       = clk_div & ~clk_div_d;
  assign button_out = (state == IDLE_HIGH) || (state == PEND_LOW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE_LOW;
      count     <= '0;
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      clk_div_d <= 1'b1;
      pressed   <= 1'b0;
      released  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      btn_meta  <= button_in;
      btn_sync  <= btn_meta;
      clk_div_d <= clk_div;
      pressed   <= pressed_next;
      released  <= released_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    pressed_next  = 1'b0;
    released_next = 1'b0;
    if (tick) begin
      case (state)
        IDLE_LOW: begin
          if (btn_sync) begin
            if (STABLE_COUNT == 1) begin
              state_next   = IDLE_HIGH;
              count_next   = '0;
              pressed_next = 1'b1;
            end else begin
              state_next = PEND_HIGH;
              count_next = COUNT_ONE;
            end
          end else begin
            count_next = '0;
          end
        end
        PEND_HIGH: begin
          if (!btn_sync) begin
            state_next = IDLE_LOW;
            count_next = '0;
          end else if (count == COUNT_LAST) begin
            state_next   = IDLE_HIGH;
            count_next   = '0;
            pressed_next = 1'b1;
          end else begin
            count_next = count + COUNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!btn_sync) begin
            if (STABLE_COUNT == 1) begin
              state_next    = IDLE_LOW;
              count_next    = '0;
              released_next = 1'b1;
            end else begin
              state_next = PEND_LOW;
              count_next = COUNT_ONE;
            end
          end else begin
            count_next = '0;
          end
        end
        PEND_LOW: begin
          if (btn_sync) begin
            state_next = IDLE_HIGH;
            count_next = '0;
          end else if (count == COUNT_LAST) begin
            state_next    = IDLE_LOW;
            count_next    = '0;
            released_next = 1'b1;
          end else begin
            count_next = count + COUNT_ONE;
          end
        end
        default: begin
          state_next = IDLE_LOW;
          count_next = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: clk_div is driven by hand with period 8,
// STABLE_COUNT=4; a negedge monitor tallies pulses and checks edge alignment.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic clk_div;
  logic button_in;
  logic button_out;
  logic pressed;
  logic released;

  int total = 0;
  int bad   = 0;

  int   press_cnt = 0;
  int   rel_cnt   = 0;
  int   both_cnt  = 0;
  int   align_err = 0;
  bit   mon_en    = 1'b0;
  logic prev_out;

  int lat;
  bit done;
  int chg;
  int p0, r0;

  always #5 clk = ~clk;

  button_debouncer #(
    .STABLE_COUNT(4),
    .STABLE_COUNT_BIT_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_div(clk_div),
    .button_in(button_in),
    .button_out(button_out),
    .pressed(pressed),
    .released(released)
  );

  // Pulses must land exactly on the first cycle of the new level
  always @(negedge clk) begin
    if (mon_en) begin
      if (pressed === 1'b1) press_cnt++;
      if (released === 1'b1) rel_cnt++;
      if (pressed === 1'b1 && released === 1'b1) both_cnt++;
      if (pressed !== (button_out & ~prev_out)) align_err++;
      if (released !== (~button_out & prev_out)) align_err++;
    end
    prev_out = button_out;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_period();
    clk_div = 1'b1;
    cyc(4);
    clk_div = 1'b0;
    cyc(4);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_period();
  endtask

  initial begin
    // Reset with button held high
    reset = 1'b1; button_in = 1'b1; clk_div = 1'b1;
    cyc(3);
    check("rst_out", button_out, 0);
    check("rst_pressed", pressed, 0);
    check("rst_released", released, 0);
    reset = 1'b0;
    cyc(1);
    check("post_rst_out", button_out, 0);
    check("post_rst_pressed", pressed, 0);
    check("post_rst_released", released, 0);
    mon_en = 1'b1;
    cyc(2);
    clk_div = 1'b0;
    cyc(4);

    // Clean press: 4th qualifying tick flips the output
    ticks(3);
    check("press_early_out", button_out, 0);
    check("press_early_cnt", press_cnt, 0);
    clk_div = 1'b1;
    cyc(1);
    check("press_out", button_out, 1);
    check("press_pulse", pressed, 1);
    check("press_no_rel", released, 0);
    cyc(1);
    check("press_pulse_end", pressed, 0);
    cyc(2); clk_div = 1'b0; cyc(4);
    check("press_cnt1", press_cnt, 1);

    // Release
    button_in = 1'b0;
    cyc(3);
    ticks(3);
    check("rel_early_out", button_out, 1);
    check("rel_early_cnt", rel_cnt, 0);
    clk_div = 1'b1;
    cyc(1);
    check("rel_out", button_out, 0);
    check("rel_pulse", released, 1);
    check("rel_no_press", pressed, 0);
    cyc(1);
    check("rel_pulse_end", released, 0);
    cyc(2); clk_div = 1'b0; cyc(4);
    check("rel_cnt1", rel_cnt, 1);
    check("press_cnt_after_rel", press_cnt, 1);

    // Press latency from button_in edge, strobe rising together with the press
    button_in = 1'b1;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      clk_div = ((i % 8) < 4);
      cyc(1);
      lat = i + 1;
      if (button_out === 1'b1) done = 1'b1;
    end
    check("press_latency", lat, 33);
    check("lat_pulse", pressed, 1);
    cyc(1);
    check("lat_pulse_end", pressed, 0);
    clk_div = 1'b0; cyc(4);
    check("press_cnt2", press_cnt, 2);

    button_in = 1'b0;
    cyc(3);
    ticks(4);
    check("rel2_out", button_out, 0);
    check("rel_cnt2", rel_cnt, 2);

    // Bounce: low across the 2nd tick restarts the count
    button_in = 1'b1;
    cyc(3);
    tick_period();
    button_in = 1'b0;
    cyc(3);
    tick_period();
    button_in = 1'b1;
    cyc(3);
    ticks(3);
    check("bounce_early_out", button_out, 0);
    check("bounce_early_cnt", press_cnt, 2);
    clk_div = 1'b1;
    cyc(1);
    check("bounce_out", button_out, 1);
    check("bounce_pulse", pressed, 1);
    cyc(3); clk_div = 1'b0; cyc(4);
    check("press_cnt3", press_cnt, 3);

    // Stuck strobe: clk_div held high, button toggles, nothing moves
    clk_div = 1'b1;
    cyc(1);
    p0 = press_cnt; r0 = rel_cnt; chg = 0;
    for (int i = 0; i < 100; i++) begin
      button_in = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
      if (button_out !== 1'b1) chg++;
    end
    check("stuck_out_changes", chg, 0);
    check("stuck_press", press_cnt - p0, 0);
    check("stuck_rel", rel_cnt - r0, 0);
    button_in = 1'b1;
    cyc(3); clk_div = 1'b0; cyc(4);

    // Reset mid-pending discards the count
    button_in = 1'b0;
    cyc(3);
    ticks(4);
    check("rel3_out", button_out, 0);
    check("rel_cnt3", rel_cnt, 3);
    button_in = 1'b1;
    cyc(3);
    ticks(3);
    check("pend3_out", button_out, 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_out", button_out, 0);
    check("midrst_pressed", pressed, 0);
    cyc(3);
    ticks(3);
    check("midrst_early_out", button_out, 0);
    check("midrst_early_cnt", press_cnt, 3);
    clk_div = 1'b1;
    cyc(1);
    check("midrst_out_hi", button_out, 1);
    check("midrst_pulse", pressed, 1);
    cyc(3); clk_div = 1'b0; cyc(4);

    check("press_cnt_final", press_cnt, 4);
    check("rel_cnt_final", rel_cnt, 3);
    check("both_pulses", both_cnt, 0);
    check("pulse_alignment", align_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
